// File: rtl/deser_4x1_pkg.sv
// Types and widths shared by the 4x1 deserializer and its slot demultiplexer.
`include "deser_defs.vh"

package deser_4x1_pkg;

  localparam int WORD_W = `DESER_WORD_W;
  localparam int SLOT_W = `DESER_SLOT_W;

  // Slot index of the last bit of a word; accepting it completes the word.
  localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(WORD_W - 1);

  typedef enum logic {
    ST_FILL = `DESER_FILL,
    ST_HOLD = `DESER_HOLD
  } state_t;

endpackage

// File: rtl/deser_4x1_demux.sv
// 2-bit-key demux: steers one data bit and its load strobe to one of four capture slots.
// Purely combinational; no state and no backpressure of its own.
module demux_2x1
  import deser_4x1_pkg::*;
(
  input  logic              data,
  input  logic [SLOT_W-1:0] key,
  input  logic              enable,
  output logic [WORD_W-1:0] sel,
  output logic [WORD_W-1:0] dout
);

  always_comb begin
    sel  = '0;
    dout = '0;
    if (enable) begin
      sel[key]  = 1'b1;
      dout[key] = data;
    end
  end

endmodule

// File: rtl/deser_defs.vh
// Shared encodings and widths for the serial capture stage.
`ifndef DESER_DEFS_VH
`define DESER_DEFS_VH

`define DESER_FILL   1'b0
`define DESER_HOLD   1'b1
`define DESER_WORD_W 4
`define DESER_SLOT_W 2

`endif

// File: rtl/deser_4x1.sv
// 1-bit to 4-bit deserializer; out_valid rises on the edge accepting bit 4, word held while out_ready=0.
// DESER_4X1_MSB_FIRST_EN places the first accepted bit in out_data[3] instead of out_data[0].
module deser_4x1
  import deser_4x1_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic              in_valid,
  input  logic              in_data,
  output logic              in_ready,
  output logic              out_valid,
  output logic [WORD_W-1:0] out_data,
  input  logic              out_ready,
  output logic [SLOT_W-1:0] slot
);

  state_t              state_q;
  state_t              state_d;
  logic                accept;
  logic [SLOT_W-1:0]   slot_q;
  logic [SLOT_W-1:0]   demux_key;
  logic [WORD_W-1:0]   load_en;
  logic [WORD_W-1:0]   load_dat;
  logic [WORD_W-1:0]   cap_q;

  assign accept = in_ready & in_valid;

`ifdef DESER_4X1_MSB_FIRST_EN
  assign demux_key = ~slot_q;
`else
  assign demux_key = slot_q;
`endif

  demux_2x1 u_demux (
    .data   (in_data),
    .key    (demux_key),
    .enable (accept),
    .sel    (load_en),
    .dout   (load_dat)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_FILL;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_FILL: if (accept && slot_q == SLOT_LAST) state_d = ST_HOLD;
      ST_HOLD: if (out_ready) state_d = ST_FILL;
      default: state_d = ST_FILL;
    endcase
    // Abort wins over both the word-completing accept and the downstream transfer.
    if (clear) state_d = ST_FILL;
  end

  always_comb begin
    in_ready  = (state_q == ST_FILL);
    out_valid = (state_q == ST_HOLD);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      slot_q <= '0;
    end else if (clear) begin
      slot_q <= '0;
    end else if (accept) begin
      slot_q <= slot_q + SLOT_W'(1);
    end
  end

  // Only the slot selected by the demux loads; the other three keep their bits.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cap_q <= '0;
    end else if (clear) begin
      cap_q <= '0;
    end else begin
      for (int i = 0; i < WORD_W; i++) begin
        if (load_en[i]) cap_q[i] <= load_dat[i];
      end
    end
  end

  assign out_data = cap_q;
  assign slot     = slot_q;

endmodule

// File: tb/tb_deser_4x1.sv
// Scoreboard bench for deser_4x1: expected words queued at stimulus, compared on each output transfer.
module tb_deser_4x1;

  logic       clk = 1'b0;
  logic       reset;
  logic       clear;
  logic       in_valid;
  logic       in_data;
  logic       in_ready;
  logic       out_valid;
  logic [3:0] out_data;
  logic       out_ready;
  logic [1:0] slot;

  int         checks = 0;
  int         errors = 0;
  int         cyc = 0;
  logic [3:0] exp_q[$];
  int         pop_cyc[$];

`ifdef DESER_4X1_MSB_FIRST_EN
  localparam logic [3:0] T1_EXP = 4'b1011;
`else
  localparam logic [3:0] T1_EXP = 4'b1101;
`endif

  deser_4x1 dut (
    .clk       (clk),
    .reset     (reset),
    .clear     (clear),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ready (out_ready),
    .slot      (slot)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // arr[i] is the i-th bit in arrival order.
  function automatic logic [3:0] exp_of(input logic [3:0] arr);
`ifdef DESER_4X1_MSB_FIRST_EN
    return {arr[0], arr[1], arr[2], arr[3]};
`else
    return arr;
`endif
  endfunction

  task automatic send_bit(input logic b);
    bit done = 1'b0;
    in_valid = 1'b1;
    in_data  = b;
    for (int k = 0; k < 40 && !done; k++) begin
      @(negedge clk);
      done = in_ready;
      @(posedge clk); #1;
    end
    if (!done) chk("send_timeout", 0, 1);
    in_valid = 1'b0;
  endtask

  task automatic send_word(input logic [3:0] arr);
    exp_q.push_back(exp_of(arr));
    for (int i = 0; i < 4; i++) send_bit(arr[i]);
  endtask

  task automatic drain(input string tag);
    for (int k = 0; k < 30 && exp_q.size() != 0; k++) @(posedge clk);
    #1;
    chk(tag, exp_q.size(), 0);
  endtask

  always @(negedge clk) begin
    if (!reset && out_valid && out_ready) begin
      pop_cyc.push_back(cyc);
      if (exp_q.size() == 0) chk("sb_unexpected", 1, 0);
      else chk("sb_word", out_data, exp_q.pop_front());
    end
  end

  initial begin
    int         n;
    logic [3:0] w;
    logic [3:0] arr;

    reset = 1'b1; clear = 1'b0; in_valid = 1'b0; in_data = 1'b0; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_slot", slot, 0);
    reset = 1'b0;
    @(posedge clk); #1;

    // Gapless word 1,0,1,1.
    send_word(4'b1101);
    chk("t1_out_valid", out_valid, 1);
    chk("t1_in_ready", in_ready, 0);
    chk("t1_data", out_data, T1_EXP);
    chk("t1_slot_wrap", slot, 0);
    @(posedge clk); #1;
    chk("t1_in_ready_back", in_ready, 1);
    chk("t1_out_valid_drop", out_valid, 0);
    chk("t1_data_retained", out_data, T1_EXP);
    drain("t1_drain");

    // Word 1,1,0,0 with two idle cycles after each bit.
    arr = 4'b0011;
    exp_q.push_back(exp_of(arr));
    for (int i = 0; i < 4; i++) begin
      send_bit(arr[i]);
      if (i < 3) begin
        repeat (2) begin
          @(posedge clk); #1;
          chk("t2_gap_slot", slot, i + 1);
        end
      end
    end
    chk("t2_valid", out_valid, 1);
    drain("t2_drain");

    // Backpressure: word held for 10 cycles while upstream keeps offering bits.
    out_ready = 1'b0;
    w = 4'($urandom_range(0, 15));
    send_word(w);
    for (int k = 0; k < 10; k++) begin
      in_valid = 1'b1;
      in_data  = k[0];
      @(posedge clk); #1;
      chk("t3_hold_valid", out_valid, 1);
      chk("t3_hold_data", out_data, exp_of(w));
      chk("t3_hold_slot", slot, 0);
      chk("t3_hold_ready", in_ready, 0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("t3_release", in_ready, 1);
    chk("t3_queue", exp_q.size(), 0);

    // Clear after 2 bits, with a bit offered in the same cycle.
    send_bit(1'b1);
    send_bit(1'b1);
    chk("t4_pre_slot", slot, 2);
    clear = 1'b1; in_valid = 1'b1; in_data = 1'b1;
    @(posedge clk); #1;
    clear = 1'b0; in_valid = 1'b0;
    chk("t4_clr_slot", slot, 0);
    chk("t4_clr_data", out_data, 0);
    chk("t4_clr_ready", in_ready, 1);
    send_word(4'b0010);
    chk("t4_word", out_data, exp_of(4'b0010));
    drain("t4_drain");

    // Asynchronous reset mid-word.
    send_bit(1'b1);
    send_bit(1'b1);
    send_bit(1'b1);
    chk("t5_pre_slot", slot, 3);
    #2;
    reset = 1'b1;
    #1;
    chk("t5_rst_slot", slot, 0);
    chk("t5_rst_data", out_data, 0);
    chk("t5_rst_ready", in_ready, 1);
    chk("t5_rst_valid", out_valid, 0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    @(posedge clk); #1;

    // Back-to-back words 0xA then 0x5 (arrival order LSB of the value first).
    n = pop_cyc.size();
    send_word(4'b1010);
    send_word(4'b0101);
    drain("t6_drain");
    chk("t6_pulses", pop_cyc.size(), n + 2);
    if (pop_cyc.size() >= n + 2) chk("t6_spacing", pop_cyc[n+1] - pop_cyc[n], 5);

    repeat (3) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule
